// File: rtl/bit_gather_packer_pkg.sv
// Shared types and helpers for the bit gather packer: FSM states,
// words-per-snapshot computation and drop counter width.
package bit_gather_packer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int DROP_W = 8;

  function automatic int calc_nwords(input int nbits, input int word_w);
    return (nbits + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/bit_gather_word_sel.sv
// Combinational word selector: returns word idx of the snapshot, with bit
// positions beyond NBITS reading as zero.
module bit_gather_word_sel
  import bit_gather_packer_pkg::*;
#(
  parameter int NBITS  = 200,
  parameter int WORD_W = 32,
  parameter int IDX_W  = 3
) (
  input  logic [NBITS-1:0]  snap,
  input  logic [IDX_W-1:0]  idx,
  output logic [WORD_W-1:0] word
);

  // Padding covers every encodable index, so no slice can leave the vector.
  localparam int PAD_W = (2 ** IDX_W) * WORD_W;

  logic [PAD_W-1:0] padded_s;

  // Zero-extend the snapshot and pick the addressed word.
  always_comb begin
    padded_s = '0;
    padded_s[NBITS-1:0] = snap;
    word = padded_s[int'(idx) * WORD_W +: WORD_W];
  end

endmodule

// File: rtl/bit_gather_packer.sv
// Snapshots NBITS scalar bits on i_capture and streams them as WORD_W words
// over valid/ready. Optional o_parity output under BIT_GATHER_PACKER_PARITY_EN.
module bit_gather_packer
  import bit_gather_packer_pkg::*;
#(
  parameter int NBITS  = 200,
  parameter int WORD_W = 32,
  localparam int NWORDS = calc_nwords(NBITS, WORD_W),
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NBITS-1:0]  i_bits,
  input  logic              i_capture,
  output logic              o_busy,
  output logic [WORD_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_last,
  output logic [IDX_W-1:0]  o_index,
  output logic [DROP_W-1:0] o_drop_cnt
`ifdef BIT_GATHER_PACKER_PARITY_EN
  ,
  output logic              o_parity
`endif
);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NWORDS - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  state_t              state_r, state_s;
  logic [NBITS-1:0]    snap_r;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [DROP_W-1:0]   drop_cnt_r;
  logic                load_s;
  logic                drop_inc_s;
  logic                xfer_s;
  logic [WORD_W-1:0]   word_s;

  // Next-state, index advance, snapshot load and drop decisions.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    load_s     = 1'b0;
    drop_inc_s = 1'b0;
    xfer_s     = (state_r == SEND) && i_ready;
    case (state_r)
      IDLE: begin
        if (i_capture) begin
          load_s  = 1'b1;
          idx_s   = '0;
          state_s = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (xfer_s && (idx_r == LAST_IDX)) begin
          // A capture on the final handshake chains straight into a new snapshot.
          if (i_capture) begin
            load_s  = 1'b1;
            idx_s   = '0;
            state_s = SEND;
          end else begin
            idx_s   = '0;
            state_s = IDLE;
          end
        end else begin
          if (xfer_s) begin
            idx_s = idx_r + IDX_W'(1);
          end else begin
            idx_s = idx_r;
          end
          drop_inc_s = i_capture;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = '0;
      end
    endcase
  end

  // State, snapshot, index and saturating drop counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      snap_r     <= '0;
      idx_r      <= '0;
      drop_cnt_r <= '0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      if (load_s) begin
        snap_r <= i_bits;
      end
      if (drop_inc_s && (drop_cnt_r != DROP_MAX)) begin
        drop_cnt_r <= drop_cnt_r + DROP_W'(1);
      end
    end
  end

  bit_gather_word_sel #(
    .NBITS  (NBITS),
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_word_sel (
    .snap (snap_r),
    .idx  (idx_r),
    .word (word_s)
  );

  assign o_valid    = (state_r == SEND);
  assign o_busy     = (state_r == SEND);
  assign o_last     = (state_r == SEND) && (idx_r == LAST_IDX);
  assign o_index    = idx_r;
  assign o_data     = word_s;
  assign o_drop_cnt = drop_cnt_r;

`ifdef BIT_GATHER_PACKER_PARITY_EN
  function automatic logic calc_parity(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction

  assign o_parity = calc_parity(word_s);
`endif

endmodule

// File: tb/tb_bit_gather_packer.sv
// Scoreboard bench for bit_gather_packer: expected words are queued at capture
// and compared on each handshake; scenario tasks add their own inline checks.
module tb_bit_gather_packer;

  localparam int NB = 200;
  localparam int WW = 32;
  localparam int NW = 7;

  typedef struct {
    logic [WW-1:0] data;
    logic [2:0]    idx;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] i_bits;
  logic          i_capture;
  logic          o_busy;
  logic [WW-1:0] o_data;
  logic          o_valid;
  logic          i_ready;
  logic          o_last;
  logic [2:0]    o_index;
  logic [7:0]    o_drop_cnt;
`ifdef BIT_GATHER_PACKER_PARITY_EN
  logic          o_parity;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t mon_e;

  bit_gather_packer dut (
    .clk        (clk),
    .rst        (rst),
    .i_bits     (i_bits),
    .i_capture  (i_capture),
    .o_busy     (o_busy),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_last     (o_last),
    .o_index    (o_index),
    .o_drop_cnt (o_drop_cnt)
`ifdef BIT_GATHER_PACKER_PARITY_EN
    ,
    .o_parity   (o_parity)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [WW-1:0] exp_word(input logic [NB-1:0] b, input int k);
    logic [WW-1:0] w;
    for (int j = 0; j < WW; j++) begin
      w[j] = (k * WW + j < NB) ? b[k * WW + j] : 1'b0;
    end
    return w;
  endfunction

  // Handshake monitor: pop and compare one expected word per transfer.
  always @(negedge clk) begin
    if (o_valid === 1'b1 && i_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: unexpected word idx=%0d data=%h", o_index, o_data);
      end else begin
        mon_e = sb.pop_front();
        if (o_data !== mon_e.data || o_index !== mon_e.idx || o_last !== mon_e.last) begin
          errors++;
          $display("FAIL sb_word: got idx=%0d data=%h last=%b, want idx=%0d data=%h last=%b",
                   o_index, o_data, o_last, mon_e.idx, mon_e.data, mon_e.last);
        end
      end
    end
  end

  task automatic do_capture(input logic [NB-1:0] b);
    exp_t e;
    i_bits    = b;
    i_capture = 1'b1;
    for (int k = 0; k < NW; k++) begin
      e.data = exp_word(b, k);
      e.idx  = 3'(k);
      e.last = (k == NW - 1);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    i_capture = 1'b0;
  endtask

  function automatic logic [NB-1:0] rand_bits();
    logic [NB-1:0] r;
    for (int k = 0; k < NW; k++) begin
      r[k * WW +: WW] = (k * WW + WW <= NB) ? $urandom : ($urandom & 32'h0000_00FF);
    end
    return r;
  endfunction

  task automatic test_reset();
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b busy=%b last=%b, want 0 0 0", o_valid, o_busy, o_last);
    end
    checks++;
    if (o_index !== 3'd0 || o_data !== 32'h0 || o_drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: index=%0d data=%h drop=%0d, want 0 0 0", o_index, o_data, o_drop_cnt);
    end
  endtask

  task automatic test_single_bit();
    logic [NB-1:0] b;
    b = '0;
    b[0] = 1'b1;
    i_ready = 1'b1;
    do_capture(b);
    checks++;
    if (o_valid !== 1'b1 || o_index !== 3'd0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: valid=%b index=%0d busy=%b, want 1 0 1", o_valid, o_index, o_busy);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (o_last !== 1'b1 || o_index !== 3'd6 || o_data !== 32'h0) begin
      errors++;
      $display("FAIL single_last: last=%b index=%0d data=%h, want 1 6 0", o_last, o_index, o_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL single_done: busy=%b valid=%b pending=%0d, want 0 0 0", o_busy, o_valid, sb.size());
    end
  endtask

  task automatic test_all_ones();
    i_ready = 1'b1;
    do_capture({NB{1'b1}});
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (o_data !== 32'h0000_00FF || o_last !== 1'b1) begin
      errors++;
      $display("FAIL ones_last_word: data=%h last=%b, want 000000ff 1", o_data, o_last);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL ones_done: busy=%b pending=%0d, want 0 0", o_busy, sb.size());
    end
  endtask

  task automatic test_stall();
    logic [NB-1:0] b;
    b = rand_bits();
    i_ready = 1'b1;
    do_capture(b);
    repeat (2) @(posedge clk);
    #1;
    i_ready = 1'b0;
    i_bits  = ~b;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      i_bits = rand_bits();
      checks++;
      if (o_valid !== 1'b1 || o_index !== 3'd2 || o_data !== exp_word(b, 2)) begin
        errors++;
        $display("FAIL stall_hold: valid=%b index=%0d data=%h, want 1 2 %h",
                 o_valid, o_index, o_data, exp_word(b, 2));
      end
    end
    i_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_done: busy=%b pending=%0d, want 0 0", o_busy, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b1;
    do_capture(rand_bits());
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (o_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_bubble: valid=%b at cycle %0d, want 1", o_valid, c);
      end
    end
    checks++;
    if (o_last !== 1'b1) begin
      errors++;
      $display("FAIL b2b_last: last=%b, want 1", o_last);
    end
    do_capture(rand_bits());
    checks++;
    if (o_valid !== 1'b1 || o_index !== 3'd0 || o_drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL b2b_restart: valid=%b index=%0d drop=%0d, want 1 0 0", o_valid, o_index, o_drop_cnt);
    end
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_done: busy=%b pending=%0d, want 0 0", o_busy, sb.size());
    end
  endtask

  task automatic test_drops();
    i_ready = 1'b1;
    do_capture(rand_bits());
    i_capture = 1'b1;
    i_bits    = rand_bits();
    repeat (3) @(posedge clk);
    #1;
    i_capture = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (o_drop_cnt !== 8'd3 || o_busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL drop_three: drop=%0d busy=%b pending=%0d, want 3 0 0", o_drop_cnt, o_busy, sb.size());
    end
    i_ready = 1'b0;
    do_capture(rand_bits());
    i_capture = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    i_capture = 1'b0;
    checks++;
    if (o_drop_cnt !== 8'd255 || o_index !== 3'd0) begin
      errors++;
      $display("FAIL drop_saturate: drop=%0d index=%0d, want 255 0", o_drop_cnt, o_index);
    end
    i_ready = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL drop_done: busy=%b pending=%0d, want 0 0", o_busy, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b1;
    do_capture(rand_bits());
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_index !== 3'd3) begin
      errors++;
      $display("FAIL rstmid_pre: index=%0d, want 3", o_index);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_index !== 3'd0 || o_drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b busy=%b index=%0d drop=%0d, want 0 0 0 0",
               o_valid, o_busy, o_index, o_drop_cnt);
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_capture(rand_bits());
    checks++;
    if (o_valid !== 1'b1 || o_index !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_restart: valid=%b index=%0d, want 1 0", o_valid, o_index);
    end
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL rstmid_done: busy=%b pending=%0d, want 0 0", o_busy, sb.size());
    end
  endtask

`ifdef BIT_GATHER_PACKER_PARITY_EN
  task automatic test_parity();
    logic [NB-1:0] b;
    b = '0;
    b[2:0] = 3'b111;
    i_ready = 1'b0;
    do_capture(b);
    checks++;
    if (o_parity !== 1'b1) begin
      errors++;
      $display("FAIL parity_word7: parity=%b, want 1", o_parity);
    end
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (o_parity !== 1'b0) begin
      errors++;
      $display("FAIL parity_zero_word: parity=%b, want 0", o_parity);
    end
    repeat (6) @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    rst       = 1'b1;
    i_bits    = '0;
    i_capture = 1'b0;
    i_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single_bit();
    test_all_ones();
    test_stall();
    test_back_to_back();
    test_drops();
    test_reset_mid();
`ifdef BIT_GATHER_PACKER_PARITY_EN
    test_parity();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: pending=%0d, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
